regfile_wb_arbiter: RTL and testbench

Write-port controller for the 8x8 register file. It shares the single write port between two writeback requesters (A: ALU, B: load unit) using round-robin arbitration with valid/ready handshakes. It also runs a clear sequencer that zeroes all registers one per cycle, and it blocks requester writes while the PC latch is active. Its outputs drive the register file's write-enable, destination and data inputs directly.

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single write port of the 8x8 register file.
//   - Round-robin arbitration between writeback requesters A (ALU) and B (load)
//     using valid/ready handshakes; the winner's write appears one cycle later.
//   - Clear sequencer: a clr_req_in pulse zeroes registers 0..NREGS-1, one per
//     cycle, with clr_busy_out high for exactly the cycles showing clear writes.
//   - Requester writes are held off while pc_latch_in is high.
// Ports:
//   clka, reset_in            clock, async active-low reset
//   pc_latch_in, clr_req_in   write block, clear request pulse
//   clr_busy_out              clear sequencer active
//   a_*/b_*                   requester valid/rd/data in, ready out (comb.)
//   we_reg_out/rd_out/data_out  registered register file write port
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clka,
  input  logic              reset_in,
  input  logic              pc_latch_in,
  input  logic              clr_req_in,
  output logic              clr_busy_out,
  input  logic              a_valid_in,
  input  logic [ADDR_W-1:0] a_rd_in,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              a_ready_out,
  input  logic              b_valid_in,
  input  logic [ADDR_W-1:0] b_rd_in,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              b_ready_out,
  output logic              we_reg_out,
  output logic [ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0] data_out
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;     // register currently shown on rd_out during a clear
  logic              last_b;  // 1: B won the last grant (so A wins the next tie)
  logic              blk;
  logic              a_xfer, b_xfer;

  // Ready depends only on valids, state and the block inputs; never on the
  // other requester's ready.
  assign blk         = (state == CLEAR) | clr_req_in | pc_latch_in;
  assign a_ready_out = ~blk & a_valid_in & (~b_valid_in | last_b);
  assign b_ready_out = ~blk & b_valid_in & (~a_valid_in | ~last_b);
  assign a_xfer      = a_ready_out;   // ready already implies valid
  assign b_xfer      = b_ready_out;

  assign clr_busy_out = (state == CLEAR);

  // The first clear write is issued on the IDLE->CLEAR edge so that every
  // cycle with clr_busy_out high carries one clear write (rd 0..NREGS-1).
  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      cnt        <= '0;
      last_b     <= 1'b1;
      we_reg_out <= 1'b0;
      rd_out     <= '0;
      data_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req_in) begin
            state      <= CLEAR;
            cnt        <= '0;
            we_reg_out <= 1'b1;
            rd_out     <= '0;
            data_out   <= '0;
          end else if (a_xfer) begin
            we_reg_out <= 1'b1;
            rd_out     <= a_rd_in;
            data_out   <= a_data_in;
            last_b     <= 1'b0;
          end else if (b_xfer) begin
            we_reg_out <= 1'b1;
            rd_out     <= b_rd_in;
            data_out   <= b_data_in;
            last_b     <= 1'b1;
          end else begin
            we_reg_out <= 1'b0;
          end
        end
        CLEAR: begin
          // clr_req_in is ignored here: a clear never restarts.
          if (cnt == LAST_REG) begin
            state      <= IDLE;
            we_reg_out <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            we_reg_out <= 1'b1;
            rd_out     <= cnt + 1'b1;
            data_out   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  logic       clka = 1'b0;
  logic       reset_in;
  logic       pc_latch_in, clr_req_in, clr_busy_out;
  logic       a_valid_in, a_ready_out, b_valid_in, b_ready_out;
  logic [2:0] a_rd_in, b_rd_in, rd_out;
  logic [7:0] a_data_in, b_data_in, data_out;
  logic       we_reg_out;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) dut (
    .clka(clka), .reset_in(reset_in), .pc_latch_in(pc_latch_in),
    .clr_req_in(clr_req_in), .clr_busy_out(clr_busy_out),
    .a_valid_in(a_valid_in), .a_rd_in(a_rd_in), .a_data_in(a_data_in),
    .a_ready_out(a_ready_out),
    .b_valid_in(b_valid_in), .b_rd_in(b_rd_in), .b_data_in(b_data_in),
    .b_ready_out(b_ready_out),
    .we_reg_out(we_reg_out), .rd_out(rd_out), .data_out(data_out)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 2 units after the edge.
  task automatic tick();
    @(posedge clka);
    #2;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    @(posedge clka);
    @(posedge clka);
    #2 reset_in = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [2:0] rd, input logic [7:0] d);
    chk({tag, "_we"}, 32'(we_reg_out), 32'(we));
    chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
    chk({tag, "_data"}, 32'(data_out), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_in = 1'b0; pc_latch_in = 1'b0; clr_req_in = 1'b0;
    a_valid_in = 1'b0; a_rd_in = '0; a_data_in = '0;
    b_valid_in = 1'b0; b_rd_in = '0; b_data_in = '0;

    // Reset state
    #12;
    chk_wr("rst", 1'b0, 3'd0, 8'h00);
    chk("rst_busy", 32'(clr_busy_out), 32'd0);
    @(posedge clka); #2 reset_in = 1'b1;

    // A only
    a_valid_in = 1'b1; a_rd_in = 3'd3; a_data_in = 8'h5A;
    #1;
    chk("aonly_ardy", 32'(a_ready_out), 32'd1);
    chk("aonly_brdy", 32'(b_ready_out), 32'd0);
    tick();
    a_valid_in = 1'b0;
    chk_wr("aonly_wr", 1'b1, 3'd3, 8'h5A);
    tick();
    chk_wr("aonly_idle", 1'b0, 3'd3, 8'h5A);

    // Tie round-robin after reset: A, B, A, B
    do_reset();
    a_valid_in = 1'b1; a_rd_in = 3'd1; a_data_in = 8'h11;
    b_valid_in = 1'b1; b_rd_in = 3'd2; b_data_in = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ardy", 32'(a_ready_out), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_brdy", 32'(b_ready_out), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      if (i % 2 == 0) chk_wr("rr_wrA", 1'b1, 3'd1, 8'h11);
      else            chk_wr("rr_wrB", 1'b1, 3'd2, 8'h22);
    end
    a_valid_in = 1'b0; b_valid_in = 1'b0;

    // PC latch block for 3 cycles
    pc_latch_in = 1'b1;
    a_valid_in = 1'b1; a_rd_in = 3'd5; a_data_in = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pc_ardy", 32'(a_ready_out), 32'd0);
      tick();
      chk("pc_we", 32'(we_reg_out), 32'd0);
    end
    pc_latch_in = 1'b0;
    #1;
    chk("pc_rel_ardy", 32'(a_ready_out), 32'd1);
    tick();
    a_valid_in = 1'b0;
    chk_wr("pc_rel_wr", 1'b1, 3'd5, 8'h77);

    // Clear sequence with A waiting
    clr_req_in = 1'b1;
    tick();
    clr_req_in = 1'b0;
    a_valid_in = 1'b1; a_rd_in = 3'd6; a_data_in = 8'h99;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("clr_busy", 32'(clr_busy_out), 32'd1);
      chk("clr_ardy", 32'(a_ready_out), 32'd0);
      chk_wr("clr_wr", 1'b1, 3'(i), 8'h00);
      tick();
    end
    #1;
    chk("clr_end_busy", 32'(clr_busy_out), 32'd0);
    chk("clr_end_we", 32'(we_reg_out), 32'd0);
    chk("clr_end_ardy", 32'(a_ready_out), 32'd1);
    tick();
    a_valid_in = 1'b0;
    chk_wr("clr_after_wr", 1'b1, 3'd6, 8'h99);

    // Clear collides with B valid; second request mid-clear is ignored
    b_valid_in = 1'b1; b_rd_in = 3'd4; b_data_in = 8'h44;
    clr_req_in = 1'b1;
    #1;
    chk("col_brdy", 32'(b_ready_out), 32'd0);
    tick();
    clr_req_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) clr_req_in = 1'b1;
      #1;
      chk("col_busy", 32'(clr_busy_out), 32'd1);
      chk("col_brdy_clr", 32'(b_ready_out), 32'd0);
      chk_wr("col_wr", 1'b1, 3'(i), 8'h00);
      tick();
      clr_req_in = 1'b0;
    end
    #1;
    chk("col_end_busy", 32'(clr_busy_out), 32'd0);
    chk("col_end_we", 32'(we_reg_out), 32'd0);
    chk("col_retry_brdy", 32'(b_ready_out), 32'd1);
    tick();
    b_valid_in = 1'b0;
    chk_wr("col_retry_wr", 1'b1, 3'd4, 8'h44);

    // Reset mid-clear, then A wins the first tie (last grant was B)
    clr_req_in = 1'b1;
    tick();
    clr_req_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_wr("mid_wr4", 1'b1, 3'd4, 8'h00);
    reset_in = 1'b0;
    #1;
    chk_wr("mid_rst", 1'b0, 3'd0, 8'h00);
    chk("mid_rst_busy", 32'(clr_busy_out), 32'd0);
    #1 reset_in = 1'b1;
    a_valid_in = 1'b1; a_rd_in = 3'd7; a_data_in = 8'hA7;
    b_valid_in = 1'b1; b_rd_in = 3'd2; b_data_in = 8'hB2;
    #1;
    chk("post_ardy", 32'(a_ready_out), 32'd1);
    chk("post_brdy", 32'(b_ready_out), 32'd0);
    tick();
    chk_wr("post_wrA", 1'b1, 3'd7, 8'hA7);
    #1;
    chk("post_brdy2", 32'(b_ready_out), 32'd1);
    tick();
    a_valid_in = 1'b0; b_valid_in = 1'b0;
    chk_wr("post_wrB", 1'b1, 3'd2, 8'hB2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
